booth_weight_feeder: RTL and testbench

Upstream front-end for a chain of radix-4 Booth multiplier stages. The block latches one signed weight and encodes it into one 5-bit one-hot Booth code per stage. It then streams a vector of signed activations into stage 0 as `q` / `-q` pairs, holding the codes stable until the last activation has drained through every non-bypassed stage. Each multiplier row of the systolic array has one instance.

---
 rtl/booth_weight_feeder.sv | 137 +++++++++++++
 tb/tb_booth_weight_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_weight_feeder.sv
// Radix-4 Booth weight encoder and activation streamer feeding stage 0 of a multiplier chain.
// Optional macro BOOTH_REV_SAT_EN: saturate the negation of the most-negative activation.
module booth_weight_feeder #(
    parameter int INPUT_WIDTH    = 8,
    parameter int NUM_CODE_WIDTH = 5,
    parameter int MATRIX_SIZE    = 3,
    parameter int NUM_DIGITS     = INPUT_WIDTH / 2
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 w_valid,
    input  logic signed [INPUT_WIDTH-1:0]        w_data,
    output logic                                 w_ready,
    input  logic                                 a_valid,
    input  logic signed [INPUT_WIDTH-1:0]        a_data,
    output logic                                 a_ready,
    output logic [NUM_DIGITS*NUM_CODE_WIDTH-1:0] num_code,
    output logic signed [INPUT_WIDTH-1:0]        q_out,
    output logic signed [INPUT_WIDTH-1:0]        q_rev_out,
    output logic                                 q_valid,
    output logic [$clog2(2*NUM_DIGITS+1)-1:0]    drain_len,
    output logic                                 busy,
    output logic                                 done
);

    localparam int DLW = $clog2(2*NUM_DIGITS+1);
    localparam int CW  = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam logic [CW-1:0] LAST_ACT = CW'(MATRIX_SIZE - 1);

    localparam logic [NUM_CODE_WIDTH-1:0] CODE_ZERO = 5'b10000;
    localparam logic [NUM_CODE_WIDTH-1:0] CODE_P1   = 5'b00010;
    localparam logic [NUM_CODE_WIDTH-1:0] CODE_P2   = 5'b01000;
    localparam logic [NUM_CODE_WIDTH-1:0] CODE_M2   = 5'b00100;
    localparam logic [NUM_CODE_WIDTH-1:0] CODE_M1   = 5'b00001;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t                                state;
    logic [CW-1:0]                         a_cnt;
    logic [DLW-1:0]                        d_cnt;
    logic [INPUT_WIDTH:0]                  w_ext;
    logic [NUM_CODE_WIDTH-1:0]             dcode;
    logic [DLW-1:0]                        nz_cnt;
    logic [NUM_DIGITS*NUM_CODE_WIDTH-1:0]  code_next;
    logic [DLW-1:0]                        drain_next;
    logic signed [INPUT_WIDTH-1:0]         rev_next;

    // w_ext carries the implicit w[-1]=0 so digit i reads w_ext[2i +: 3]
    always_comb begin
        w_ext     = {w_data, 1'b0};
        code_next = '0;
        nz_cnt    = '0;
        dcode     = CODE_ZERO;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            case (w_ext[2*i +: 3])
                3'b001, 3'b010: dcode = CODE_P1;
                3'b011:         dcode = CODE_P2;
                3'b100:         dcode = CODE_M2;
                3'b101, 3'b110: dcode = CODE_M1;
                default:        dcode = CODE_ZERO;
            endcase
            if (dcode != CODE_ZERO) nz_cnt = nz_cnt + DLW'(1);
            code_next[(NUM_DIGITS-1-i)*NUM_CODE_WIDTH +: NUM_CODE_WIDTH] = dcode;
        end
        drain_next = nz_cnt << 1;
    end

    always_comb begin
        rev_next = -a_data;
`ifdef BOOTH_REV_SAT_EN
        if (a_data == {1'b1, {(INPUT_WIDTH-1){1'b0}}})
            rev_next = {1'b0, {(INPUT_WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            num_code  <= {NUM_DIGITS{CODE_ZERO}};
            q_out     <= '0;
            q_rev_out <= '0;
            q_valid   <= 1'b0;
            drain_len <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            w_ready   <= 1'b1;
            a_ready   <= 1'b0;
            a_cnt     <= '0;
            d_cnt     <= '0;
        end else begin
            q_out     <= '0;
            q_rev_out <= '0;
            q_valid   <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (w_valid && w_ready) begin
                        num_code  <= code_next;
                        drain_len <= drain_next;
                        a_cnt     <= '0;
                        busy      <= 1'b1;
                        w_ready   <= 1'b0;
                        a_ready   <= 1'b1;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (a_valid && a_ready) begin
                        q_out     <= a_data;
                        q_rev_out <= rev_next;
                        q_valid   <= 1'b1;
                        if (a_cnt == LAST_ACT) begin
                            a_ready <= 1'b0;
                            d_cnt   <= drain_len;
                            state   <= DRAIN;
                        end else begin
                            a_cnt <= a_cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // counts 0 and 1 both end here, so a zero weight still drains one cycle
                    if (d_cnt <= DLW'(1)) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        w_ready <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        d_cnt <= d_cnt - DLW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_weight_feeder.sv
// Directed and randomized bench for booth_weight_feeder with an arithmetic Booth reference model.
module tb_booth_weight_feeder;

    localparam int W  = 8;
    localparam int ND = W / 2;
    localparam int CB = ND * 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              w_valid;
    logic signed [W-1:0] w_data;
    logic              w_ready;
    logic              a_valid;
    logic signed [W-1:0] a_data;
    logic              a_ready;
    logic [CB-1:0]     num_code;
    logic signed [W-1:0] q_out;
    logic signed [W-1:0] q_rev_out;
    logic              q_valid;
    logic [3:0]        drain_len;
    logic              busy;
    logic              done;

    int vectors    = 0;
    int miscompares = 0;

    booth_weight_feeder #(.INPUT_WIDTH(W), .NUM_CODE_WIDTH(5), .MATRIX_SIZE(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .num_code(num_code), .q_out(q_out), .q_rev_out(q_rev_out), .q_valid(q_valid),
        .drain_len(drain_len), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Booth digit value from its arithmetic definition: -2*b(2i+1) + b(2i) + b(2i-1)
    function automatic int digit(input logic [W-1:0] w, input int i);
        int hi, mid, lo;
        hi  = int'(w[2*i+1]);
        mid = int'(w[2*i]);
        lo  = (i == 0) ? 0 : int'(w[2*i-1]);
        return -2*hi + mid + lo;
    endfunction

    function automatic logic [4:0] code_of(input int d);
        case (d)
            1:       return 5'b00010;
            2:       return 5'b01000;
            -2:      return 5'b00100;
            -1:      return 5'b00001;
            default: return 5'b10000;
        endcase
    endfunction

    function automatic logic [CB-1:0] exp_codes(input logic [W-1:0] w);
        logic [CB-1:0] c;
        c = '0;
        for (int i = 0; i < ND; i++) c[(ND-1-i)*5 +: 5] = code_of(digit(w, i));
        return c;
    endfunction

    function automatic int exp_drain(input logic [W-1:0] w);
        int n;
        n = 0;
        for (int i = 0; i < ND; i++) if (digit(w, i) != 0) n++;
        return 2 * n;
    endfunction

    function automatic logic [W-1:0] exp_rev(input logic [W-1:0] a);
        int v;
        v = -int'($signed(a));
`ifdef BOOTH_REV_SAT_EN
        if (v == 128) v = 127;
`endif
        return W'(v);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] cur_w;

    task automatic load_weight(input logic [W-1:0] w);
        w_valid = 1'b1;
        w_data  = w;
        tick();
        w_valid = 1'b0;
        cur_w   = w;
        check("num_code_load", 64'(num_code), 64'(exp_codes(w)));
        check("drain_len_load", 64'(drain_len), 64'(exp_drain(w)));
        check("busy_load", 64'(busy), 64'd1);
        check("a_ready_load", 64'(a_ready), 64'd1);
        check("w_ready_load", 64'(w_ready), 64'd0);
    endtask

    task automatic send(input logic [W-1:0] a, input logic v, input logic poke_w);
        a_valid = v;
        a_data  = a;
        w_valid = poke_w;
        w_data  = ~cur_w;
        tick();
        a_valid = 1'b0;
        w_valid = 1'b0;
        check("q_valid", 64'(q_valid), 64'(v));
        check("q_out", 64'($unsigned(q_out)), v ? 64'(a) : 64'd0);
        check("q_rev_out", 64'($unsigned(q_rev_out)), v ? 64'(exp_rev(a)) : 64'd0);
        if (poke_w) check("num_code_stream", 64'(num_code), 64'(exp_codes(cur_w)));
    endtask

    task automatic finish_drain();
        int lat;
        lat = (exp_drain(cur_w) == 0) ? 1 : exp_drain(cur_w);
        check("a_ready_drain", 64'(a_ready), 64'd0);
        for (int k = 1; k <= lat; k++) begin
            a_valid = 1'b1;
            a_data  = W'($urandom);
            w_valid = 1'b1;
            w_data  = ~cur_w;
            tick();
            check("done_timing", 64'(done), 64'(k == lat));
            check("busy_drain", 64'(busy), 64'(k != lat));
            check("q_valid_drain", 64'(q_valid), 64'd0);
            check("num_code_hold", 64'(num_code), 64'(exp_codes(cur_w)));
        end
        a_valid = 1'b0;
        w_valid = 1'b0;
        tick();
        check("done_pulse_end", 64'(done), 64'd0);
        check("w_ready_idle", 64'(w_ready), 64'd1);
    endtask

    task automatic check_reset_state();
        check("rst_num_code", 64'(num_code), 64'({ND{5'b10000}}));
        check("rst_q_out", 64'($unsigned(q_out)), 64'd0);
        check("rst_q_rev", 64'($unsigned(q_rev_out)), 64'd0);
        check("rst_q_valid", 64'(q_valid), 64'd0);
        check("rst_drain_len", 64'(drain_len), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_w_ready", 64'(w_ready), 64'd1);
        check("rst_a_ready", 64'(a_ready), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        w_valid = 1'b0;
        w_data  = '0;
        a_valid = 1'b0;
        a_data  = '0;
        cur_w   = '0;
        repeat (2) tick();
        check_reset_state();
        reset_n = 1'b1;

        // a_valid in IDLE is ignored
        a_valid = 1'b1;
        a_data  = 8'sd9;
        tick();
        a_valid = 1'b0;
        check("idle_q_valid", 64'(q_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        load_weight(8'sd7);
        check("w7_codes_const", 64'(num_code), 64'(20'b00001_01000_10000_10000));
        check("w7_drain_const", 64'(drain_len), 64'd4);
        send(8'sd3, 1'b1, 1'b0);
        send(-8'sd5, 1'b1, 1'b0);
        send(8'sd1, 1'b1, 1'b0);
        finish_drain();

        load_weight(8'h80);
        check("wm128_codes_const", 64'(num_code), 64'(20'b10000_10000_10000_00100));
        check("wm128_drain_const", 64'(drain_len), 64'd2);
        send(8'h80, 1'b1, 1'b0);
`ifdef BOOTH_REV_SAT_EN
        check("rev_sat_const", 64'($unsigned(q_rev_out)), 64'h7f);
`else
        check("rev_wrap_const", 64'($unsigned(q_rev_out)), 64'h80);
`endif
        send(8'h7f, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        finish_drain();

        load_weight(8'hff);
        check("wm1_codes_const", 64'(num_code), 64'(20'b00001_10000_10000_10000));
        send(8'h11, 1'b1, 1'b0);
        send(8'h5a, 1'b0, 1'b1);
        send(8'hc3, 1'b1, 1'b0);
        send(8'h22, 1'b0, 1'b1);
        send(8'h81, 1'b1, 1'b0);
        finish_drain();

        load_weight(8'h00);
        check("w0_drain_const", 64'(drain_len), 64'd0);
        send(8'sd4, 1'b1, 1'b0);
        send(8'sd5, 1'b1, 1'b0);
        send(-8'sd6, 1'b1, 1'b0);
        finish_drain();

        // reset mid-stream discards the partial vector
        load_weight(8'h5b);
        send(8'sd10, 1'b1, 1'b0);
        send(8'sd20, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_reset_state();
        tick();
        reset_n = 1'b1;
        tick();
        load_weight(8'h2c);
        send(8'sd1, 1'b1, 1'b0);
        send(8'sd2, 1'b1, 1'b0);
        send(8'sd3, 1'b1, 1'b0);
        finish_drain();

        for (int n = 0; n < 12; n++) begin
            int acc;
            load_weight(W'($urandom));
            acc = 0;
            while (acc < 3) begin
                logic v;
                v = ($urandom_range(0, 3) != 0);
                send(W'($urandom), v, ($urandom_range(0, 4) == 0));
                if (v) acc++;
            end
            finish_drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
